// File: rtl/batalla_game_ctrl.sv
// Game controller for the 5x5 battleship game. Owns both boards, the cursor,
// the turn sequencing, a pseudo-random PC opponent and the player turn timer.
// Every output comes straight from a register and feeds the VGA stage directly.
module batalla_game_ctrl #(
   parameter int unsigned SHIPS       = 5,
   parameter int unsigned TURN_CYCLES = 250000000,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  btn_left,
   input  logic                  btn_right,
   input  logic                  btn_fire,
   input  logic                  btn_start,
   output logic [2:0]            i_actual,
   output logic [2:0]            j_actual,
   output logic [4:0][4:0][1:0]  tablero_jugador,
   output logic [4:0][4:0][1:0]  tablero_pc,
   output logic [2:0]            estado,
   output logic [1:0]            ganador,
   output logic [2:0]            hits_jugador,
   output logic [2:0]            hits_pc
);

   localparam logic [2:0] PLACE_PLAYER = 3'd0;
   localparam logic [2:0] PLACE_PC     = 3'd1;
   localparam logic [2:0] PLAYER_TURN  = 3'd2;
   localparam logic [2:0] PC_TURN      = 3'd3;
   localparam logic [2:0] GAME_OVER    = 3'd4;

   localparam logic [1:0] WATER = 2'd0;
   localparam logic [1:0] SHIP  = 2'd1;
   localparam logic [1:0] HIT   = 2'd2;
   localparam logic [1:0] MISS  = 2'd3;

   localparam int             TW      = $clog2(TURN_CYCLES);
   localparam logic [TW-1:0]  T_LAST  = TW'(TURN_CYCLES - 1);
   localparam logic [2:0]     N_SHIPS = 3'(SHIPS);

   logic [7:0]    lfsr;
   logic          lfsr_fb;
   logic [2:0]    cnt;
   logic [TW-1:0] tcnt;

   logic [2:0]    rnd_row, rnd_col;
   logic          rnd_ok;
   logic [2:0]    nxt_i, nxt_j;
   logic [1:0]    cur_j_cell, cur_pc_cell, rnd_j_cell, rnd_pc_cell;
   logic          move_ok;

   // x^8+x^6+x^5+x^4+1, maximal length, so every nonzero value shows up
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign rnd_ok  = (lfsr[4:0] < 5'd25);

   // Map the 5-bit candidate to (row, col) = (idx/5, idx%5)
   always_comb begin
      rnd_row = '0;
      rnd_col = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            if (lfsr[4:0] == 5'(r * 5 + c)) begin
               rnd_row = 3'(r);
               rnd_col = 3'(c);
            end
   end

   // Next cursor position: single move per cycle, up > down > left > right, wrapping
   always_comb begin
      nxt_i = i_actual;
      nxt_j = j_actual;
      if (btn_up)
         nxt_i = (i_actual == 3'd0) ? 3'd4 : i_actual - 3'd1;
      else if (btn_down)
         nxt_i = (i_actual == 3'd4) ? 3'd0 : i_actual + 3'd1;
      else if (btn_left)
         nxt_j = (j_actual == 3'd0) ? 3'd4 : j_actual - 3'd1;
      else if (btn_right)
         nxt_j = (j_actual == 3'd4) ? 3'd0 : j_actual + 3'd1;
   end

   assign cur_j_cell  = tablero_jugador[i_actual][j_actual];
   assign cur_pc_cell = tablero_pc[i_actual][j_actual];
   assign rnd_j_cell  = tablero_jugador[rnd_row][rnd_col];
   assign rnd_pc_cell = tablero_pc[rnd_row][rnd_col];

   // A fire pulse pins the cursor so the shot lands where the player aimed
   assign move_ok = (estado == PLACE_PLAYER || estado == PLAYER_TURN) && !btn_fire;

   // Game state machine, boards, counters, cursor and LFSR
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tablero_jugador <= '0;
         tablero_pc      <= '0;
         i_actual        <= '0;
         j_actual        <= '0;
         estado          <= PLACE_PLAYER;
         ganador         <= '0;
         hits_jugador    <= '0;
         hits_pc         <= '0;
         cnt             <= '0;
         tcnt            <= '0;
         lfsr            <= LFSR_SEED;
      end else if (estado == GAME_OVER && btn_start) begin
         // Restart: identical to power-on, including the LFSR seed
         tablero_jugador <= '0;
         tablero_pc      <= '0;
         i_actual        <= '0;
         j_actual        <= '0;
         estado          <= PLACE_PLAYER;
         ganador         <= '0;
         hits_jugador    <= '0;
         hits_pc         <= '0;
         cnt             <= '0;
         tcnt            <= '0;
         lfsr            <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr_fb};
         if (move_ok) begin
            i_actual <= nxt_i;
            j_actual <= nxt_j;
         end
         case (estado)
            PLACE_PLAYER: begin
               if (cnt == N_SHIPS) begin
                  cnt    <= '0;
                  estado <= PLACE_PC;
               end else if (btn_fire) begin
                  // Fire toggles a ship so the player can undo a placement
                  if (cur_j_cell == WATER) begin
                     tablero_jugador[i_actual][j_actual] <= SHIP;
                     cnt <= cnt + 3'd1;
                  end else if (cur_j_cell == SHIP) begin
                     tablero_jugador[i_actual][j_actual] <= WATER;
                     cnt <= cnt - 3'd1;
                  end
               end
            end
            PLACE_PC: begin
               if (cnt == N_SHIPS) begin
                  cnt    <= '0;
                  tcnt   <= '0;
                  estado <= PLAYER_TURN;
               end else if (rnd_ok && rnd_pc_cell == WATER) begin
                  tablero_pc[rnd_row][rnd_col] <= SHIP;
                  cnt <= cnt + 3'd1;
               end
            end
            PLAYER_TURN: begin
               // A valid shot wins over an expiring timer in the same cycle
               if (btn_fire && !cur_pc_cell[1]) begin
                  tablero_pc[i_actual][j_actual] <= cur_pc_cell[0] ? HIT : MISS;
                  if (cur_pc_cell[0]) hits_jugador <= hits_jugador + 3'd1;
                  if (cur_pc_cell[0] && (hits_jugador + 3'd1 == N_SHIPS)) begin
                     ganador <= 2'd1;
                     estado  <= GAME_OVER;
                  end else begin
                     estado  <= PC_TURN;
                  end
               end else if (tcnt == T_LAST) begin
                  estado <= PC_TURN;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            PC_TURN: begin
               // Rejected candidates just burn a cycle; the LFSR moves on
               if (rnd_ok && !rnd_j_cell[1]) begin
                  tablero_jugador[rnd_row][rnd_col] <= rnd_j_cell[0] ? HIT : MISS;
                  if (rnd_j_cell[0]) hits_pc <= hits_pc + 3'd1;
                  if (rnd_j_cell[0] && (hits_pc + 3'd1 == N_SHIPS)) begin
                     ganador <= 2'd2;
                     estado  <= GAME_OVER;
                  end else begin
                     tcnt   <= '0;
                     estado <= PLAYER_TURN;
                  end
               end
            end
            GAME_OVER: ;
            default: estado <= PLACE_PLAYER;
         endcase
      end
   end

endmodule
